traffic_phase_scheduler: RTL and testbench

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

---
 rtl/traffic_phase_scheduler.sv | 172 +++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Two-road traffic light phase scheduler with all-red clearance and maintenance flash.
// Optional pedestrian walk phase is compiled in with `define PED_WALK_EN.
module traffic_phase_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 16,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 6,
    parameter int FLASH_T   = 2,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m,
    input  logic       req1,
    input  logic       req2,
    input  logic       ped,
    output logic       r1,
    output logic       y1,
    output logic       g1,
    output logic       r2,
    output logic       y2,
    output logic       g2,
    output logic       walk,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_AR2   = 3'd0,
        S_G1    = 3'd1,
        S_Y1    = 3'd2,
        S_AR1   = 3'd3,
        S_G2    = 3'd4,
        S_Y2    = 3'd5,
        S_WALK  = 3'd6,
        S_FLASH = 3'd7
    } state_t;

`ifdef PED_WALK_EN
    localparam logic PED_EN = 1'b1;
`else
    localparam logic PED_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] GMIN_M1  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1  = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_M1    = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_M1  = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] FLASH_M1 = CNT_W'(FLASH_T - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ped_pending;
    logic             r_blink;
    logic             r_next_g2;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_blink_nxt;
    logic             w_ped_nxt;
    logic             w_next_g2_nxt;
    logic             w_g1_done;
    logic             w_g2_done;
    logic [6:0]       w_lamps;

    // Greens saturate their counter while resting, so ">=" keeps both limits reachable later.
    assign w_g1_done = (r_cnt >= GMIN_M1) && (req2 || r_ped_pending) && (!req1 || (r_cnt >= GMAX_M1));
    assign w_g2_done = (r_cnt >= GMIN_M1) && (req1 || r_ped_pending) && (!req2 || (r_cnt >= GMAX_M1));

    // Next-phase selection; maintenance request overrides every other transition.
    always_comb begin
        w_state_nxt   = r_state;
        w_next_g2_nxt = r_next_g2;
        if (m) begin
            w_state_nxt = S_FLASH;
        end else begin
            case (r_state)
                S_G1:    if (w_g1_done) w_state_nxt = S_Y1; else w_state_nxt = S_G1;
                S_Y1:    if (r_cnt == YEL_M1) w_state_nxt = S_AR1; else w_state_nxt = S_Y1;
                S_AR1: begin
                    if (r_cnt == AR_M1) begin
                        w_next_g2_nxt = 1'b1;
                        w_state_nxt   = r_ped_pending ? S_WALK : S_G2;
                    end else begin
                        w_state_nxt = S_AR1;
                    end
                end
                S_G2:    if (w_g2_done) w_state_nxt = S_Y2; else w_state_nxt = S_G2;
                S_Y2:    if (r_cnt == YEL_M1) w_state_nxt = S_AR2; else w_state_nxt = S_Y2;
                S_AR2: begin
                    if (r_cnt == AR_M1) begin
                        w_next_g2_nxt = 1'b0;
                        w_state_nxt   = r_ped_pending ? S_WALK : S_G1;
                    end else begin
                        w_state_nxt = S_AR2;
                    end
                end
                S_WALK: begin
                    if (r_cnt == WALK_M1) w_state_nxt = r_next_g2 ? S_G2 : S_G1;
                    else                  w_state_nxt = S_WALK;
                end
                S_FLASH: w_state_nxt = S_AR2;
                default: w_state_nxt = S_AR2;
            endcase
        end
    end

    // Dwell counter, blink phase and pedestrian latch for the coming cycle.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_blink_nxt = 1'b0;
        w_ped_nxt   = 1'b0;
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end else if ((r_state == S_FLASH) && (r_cnt == FLASH_M1)) begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
        if ((w_state_nxt == S_FLASH) && (r_state == S_FLASH)) begin
            w_blink_nxt = (r_cnt == FLASH_M1) ? ~r_blink : r_blink;
        end else begin
            w_blink_nxt = 1'b0;
        end
        if ((w_state_nxt == S_WALK) || (w_state_nxt == S_FLASH) ||
            (r_state == S_WALK) || (r_state == S_FLASH)) begin
            w_ped_nxt = 1'b0;
        end else begin
            w_ped_nxt = PED_EN & (r_ped_pending | ped);
        end
    end

    // Lamp decode of the upcoming phase: {r1, y1, g1, r2, y2, g2, walk}.
    always_comb begin
        w_lamps = 7'b000_000_0;
        case (w_state_nxt)
            S_G1:    w_lamps = 7'b001_100_0;
            S_Y1:    w_lamps = 7'b010_100_0;
            S_G2:    w_lamps = 7'b100_001_0;
            S_Y2:    w_lamps = 7'b100_010_0;
            S_WALK:  w_lamps = {6'b100_100, PED_EN};
            S_FLASH: w_lamps = {1'b0, w_blink_nxt, 2'b00, w_blink_nxt, 2'b00};
            default: w_lamps = 7'b100_100_0;
        endcase
    end

    // State, counters and registered lamp drives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_AR2;
            r_cnt         <= {CNT_W{1'b0}};
            r_ped_pending <= 1'b0;
            r_blink       <= 1'b0;
            r_next_g2     <= 1'b0;
            {r1, y1, g1, r2, y2, g2, walk} <= 7'b100_100_0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_ped_pending <= w_ped_nxt;
            r_blink       <= w_blink_nxt;
            r_next_g2     <= w_next_g2_nxt;
            {r1, y1, g1, r2, y2, g2, walk} <= w_lamps;
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed scoreboard bench for traffic_phase_scheduler; expected lamps come from a phase decode table.
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       m;
    logic       req1;
    logic       req2;
    logic       ped;
    logic       r1, y1, g1, r2, y2, g2, walk;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    logic [9:0] sb_q[$];

    localparam logic [2:0] AR2 = 3'd0, G1 = 3'd1, Y1 = 3'd2, AR1 = 3'd3,
                           G2 = 3'd4, Y2 = 3'd5, WALK = 3'd6, FLASH = 3'd7;

    traffic_phase_scheduler dut (
        .clk(clk), .rst(rst), .m(m), .req1(req1), .req2(req2), .ped(ped),
        .r1(r1), .y1(y1), .g1(g1), .r2(r2), .y2(y2), .g2(g2),
        .walk(walk), .state(state)
    );

    always #5 clk = ~clk;

    // Expected {state, r1, y1, g1, r2, y2, g2, walk} for a phase.
    function automatic logic [9:0] exp_out(input logic [2:0] st, input logic bl);
        logic [6:0] l;
        case (st)
            G1:      l = 7'b0011000;
            Y1:      l = 7'b0101000;
            G2:      l = 7'b1000010;
            Y2:      l = 7'b1000100;
            WALK:    l = 7'b1001001;
            FLASH:   l = {1'b0, bl, 1'b0, 1'b0, bl, 1'b0, 1'b0};
            default: l = 7'b1001000;
        endcase
        return {st, l};
    endfunction

    task automatic chk_now(input logic [2:0] st, input logic bl, input string tag);
        logic [9:0] e;
        logic [9:0] o;
        sb_q.push_back(exp_out(st, bl));
        e = sb_q.pop_front();
        o = {state, r1, y1, g1, r2, y2, g2, walk};
        total++;
        assert (o === e) else begin
            bad++;
            $display("FAIL %s t=%0t observed=%b expected=%b", tag, $time, o, e);
            $error("%s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic chk(input logic [2:0] st, input logic bl, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk_now(st, bl, tag);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b0; m = 1'b0; req1 = 1'b0; req2 = 1'b0; ped = 1'b0;
        @(negedge clk);
        chk_now(AR2, 1'b0, "reset_hold");

        // Road 2 demand only.
        @(negedge clk);
        req2 = 1'b1; rst = 1'b1;
        chk(AR2, 1'b0, 2, "r2_ar2");
        chk(G1,  1'b0, 4, "r2_g1");
        chk(Y1,  1'b0, 3, "r2_y1");
        chk(AR1, 1'b0, 2, "r2_ar1");
        chk(G2,  1'b0, 1, "r2_g2");

        // Asynchronous reset mid-G2, checked before the next clock edge.
        rst = 1'b0;
        #1;
        chk_now(AR2, 1'b0, "async_rst");
        @(negedge clk);

        // Both roads demanding: G1 capped at GREEN_MAX.
        req1 = 1'b1; req2 = 1'b1; rst = 1'b1;
        chk(AR2, 1'b0, 2,  "max_ar2");
        chk(G1,  1'b0, 16, "max_g1");
        chk(Y1,  1'b0, 3,  "max_y1");
        chk(AR1, 1'b0, 2,  "max_ar1");
        chk(G2,  1'b0, 1,  "max_g2");

        // Maintenance flash requested on the last Y1 cycle beats the AR1 transition.
        rst = 1'b0;
        @(negedge clk);
        req1 = 1'b0; req2 = 1'b1; rst = 1'b1;
        chk(AR2, 1'b0, 2, "fl_ar2");
        chk(G1,  1'b0, 4, "fl_g1");
        chk(Y1,  1'b0, 2, "fl_y1");
        m = 1'b1;
        chk(Y1,    1'b0, 1, "fl_y1_last");
        chk(FLASH, 1'b0, 2, "fl_b0");
        chk(FLASH, 1'b1, 2, "fl_b1");
        chk(FLASH, 1'b0, 2, "fl_b0b");
        m = 1'b0; req2 = 1'b0;
        chk(FLASH, 1'b1, 1, "fl_exit");
        chk(AR2,   1'b0, 2, "fl_ar2_after");
        chk(G1,    1'b0, 4, "fl_g1_after");

`ifdef PED_WALK_EN
        // Pedestrian press in G1, then a press during WALK that must be ignored.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk(AR2, 1'b0, 2, "pd_ar2");
        chk(G1,  1'b0, 1, "pd_g1");
        ped = 1'b1;
        chk(G1,  1'b0, 1, "pd_g1_press");
        ped = 1'b0;
        chk(G1,   1'b0, 2, "pd_g1_end");
        chk(Y1,   1'b0, 3, "pd_y1");
        chk(AR1,  1'b0, 2, "pd_ar1");
        chk(WALK, 1'b0, 2, "pd_walk");
        ped = 1'b1;
        chk(WALK, 1'b0, 1, "pd_walk_press");
        ped = 1'b0;
        chk(WALK, 1'b0, 3, "pd_walk_end");
        chk(G2,   1'b0, 8, "pd_g2_rest");
`else
        // Without the pedestrian feature a press leaves G1 resting.
        ped = 1'b1;
        chk(G1, 1'b0, 1,  "nop_press");
        ped = 1'b0;
        chk(G1, 1'b0, 12, "nop_rest");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
